// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: EX forwarding,
// load-use stalls, branch flushes and fixed-latency MDU sequencing. Optional
// performance counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MDU_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  input  logic [4:0] rs1_E,
  input  logic [4:0] rs2_E,
  input  logic [4:0] rd_E,
  input  logic [4:0] rd_M,
  input  logic [4:0] rd_W,
  input  logic       regWrite_M,
  input  logic       regWrite_W,
  input  logic       memRead_E,
  input  logic       PCSrc_E,
  input  logic       mdu_start_E,
  output logic [1:0] forwardA_E,
  output logic [1:0] forwardB_E,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       flush_D,
  output logic       flush_E,
  output logic       bubble_M,
  output logic       mdu_busy,
  output logic       mdu_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  // First cycle of the op is spent in RUN, so the wait count starts two short.
  localparam logic [3:0] CNT_INIT = (MDU_LATENCY > 1) ? 4'(MDU_LATENCY - 2) : '0;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       lu;

  always_comb begin
    forwardA_E = 2'b00;
    if (regWrite_M && (rd_M != '0) && (rd_M == rs1_E))
      forwardA_E = 2'b10;
    else if (regWrite_W && (rd_W != '0) && (rd_W == rs1_E))
      forwardA_E = 2'b01;
  end

  always_comb begin
    forwardB_E = 2'b00;
    if (regWrite_M && (rd_M != '0) && (rd_M == rs2_E))
      forwardB_E = 2'b10;
    else if (regWrite_W && (rd_W != '0) && (rd_W == rs2_E))
      forwardB_E = 2'b01;
  end

  assign lu = memRead_E && (rd_E != '0) && ((rd_E == rs1_D) || (rd_E == rs2_D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    stall_E    = 1'b0;
    flush_D    = 1'b0;
    flush_E    = 1'b0;
    bubble_M   = 1'b0;
    mdu_busy   = 1'b0;
    mdu_done   = 1'b0;
    case (state)
      RUN: begin
        if (mdu_start_E) begin
          if (MDU_LATENCY > 1) begin
            stall_F    = 1'b1;
            stall_D    = 1'b1;
            stall_E    = 1'b1;
            bubble_M   = 1'b1;
            state_next = MDU_WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            mdu_done = 1'b1;
          end
        end else if (PCSrc_E) begin
          flush_D = 1'b1;
          flush_E = 1'b1;
        end else if (lu) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
        end
      end
      MDU_WAIT: begin
        mdu_busy = 1'b1;
        if (cnt != '0) begin
          stall_F  = 1'b1;
          stall_D  = 1'b1;
          stall_E  = 1'b1;
          bubble_M = 1'b1;
          cnt_next = cnt - 4'd1;
        end else begin
          mdu_done   = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_F) stall_cycles <= stall_cycles + 32'd1;
      if (flush_D) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MDU_LATENCY 4 and 1 instances).
// Control outputs are compared as {stall_F,stall_D,stall_E,flush_D,flush_E,bubble_M,mdu_busy,mdu_done}.
module tb_hazard_ctrl;

  logic       clk, rst_n;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       regWrite_M, regWrite_W, memRead_E, PCSrc_E, mdu_start_E, mdu1_start;
  logic [1:0] forwardA_E, forwardB_E, fa1, fb1;
  logic       stall_F, stall_D, stall_E, flush_D, flush_E, bubble_M, mdu_busy, mdu_done;
  logic       s1F, s1D, s1E, f1D, f1E, b1M, busy1, done1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, sc1, fc1;
`endif

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.MDU_LATENCY(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
    .memRead_E(memRead_E), .PCSrc_E(PCSrc_E), .mdu_start_E(mdu_start_E),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E), .bubble_M(bubble_M),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  hazard_ctrl #(.MDU_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
    .memRead_E(memRead_E), .PCSrc_E(PCSrc_E), .mdu_start_E(mdu1_start),
    .forwardA_E(fa1), .forwardB_E(fb1),
    .stall_F(s1F), .stall_D(s1D), .stall_E(s1E),
    .flush_D(f1D), .flush_E(f1E), .bubble_M(b1M),
    .mdu_busy(busy1), .mdu_done(done1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc1), .flush_count(fc1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ctl();
    return {stall_F, stall_D, stall_E, flush_D, flush_E, bubble_M, mdu_busy, mdu_done};
  endfunction

  task automatic clear_inputs();
    {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
    {regWrite_M, regWrite_W, memRead_E, PCSrc_E, mdu_start_E, mdu1_start} = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    n_vec++;
    if (ctl() !== 8'b0000_0000) begin
      n_err++;
      $display("FAIL reset_ctl: got %b expected %b", ctl(), 8'b0);
    end
    n_vec++;
    if ({forwardA_E, forwardB_E} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_fwd: got %b expected 0000", {forwardA_E, forwardB_E});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    // {regWrite_M, rd_M, regWrite_W, rd_W, rs1_E, rs2_E, expA, expB}
    logic [29:0] vec [6];
    vec[0] = {1'b1, 5'd5, 1'b1, 5'd5, 5'd5,  5'd0,  2'b10, 2'b00};
    vec[1] = {1'b1, 5'd0, 1'b1, 5'd5, 5'd0,  5'd0,  2'b00, 2'b00};
    vec[2] = {1'b0, 5'd5, 1'b1, 5'd5, 5'd5,  5'd6,  2'b01, 2'b00};
    vec[3] = {1'b1, 5'd3, 1'b1, 5'd5, 5'd5,  5'd3,  2'b01, 2'b10};
    vec[4] = {1'b0, 5'd9, 1'b0, 5'd9, 5'd9,  5'd9,  2'b00, 2'b00};
    vec[5] = {1'b1, 5'd0, 1'b1, 5'd0, 5'd0,  5'd0,  2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {regWrite_M, rd_M, regWrite_W, rd_W, rs1_E, rs2_E} = vec[i][29:4];
      #1;
      n_vec++;
      if ({forwardA_E, forwardB_E} !== vec[i][3:0]) begin
        n_err++;
        $display("FAIL fwd[%0d]: got A=%b B=%b expected A=%b B=%b",
                 i, forwardA_E, forwardB_E, vec[i][3:2], vec[i][1:0]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    // {rd_E, rs1_D, rs2_D, expected ctl}
    logic [22:0] vec [4];
    vec[0] = {5'd7, 5'd0, 5'd7, 8'b1100_1000};
    vec[1] = {5'd7, 5'd7, 5'd2, 8'b1100_1000};
    vec[2] = {5'd0, 5'd0, 5'd0, 8'b0000_0000};
    vec[3] = {5'd7, 5'd6, 5'd8, 8'b0000_0000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      memRead_E = 1'b1;
      {rd_E, rs1_D, rs2_D} = vec[i][22:8];
      #1;
      n_vec++;
      if (ctl() !== vec[i][7:0]) begin
        n_err++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, ctl(), vec[i][7:0]);
      end
    end
    @(negedge clk);
    memRead_E = 1'b0;
    #1;
    n_vec++;
    if (ctl() !== 8'b0000_0000) begin
      n_err++;
      $display("FAIL load_use_release: got %b expected %b", ctl(), 8'b0);
    end
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    @(negedge clk);
    memRead_E = 1'b1; rd_E = 5'd7; rs2_D = 5'd7; PCSrc_E = 1'b1;
    #1;
    n_vec++;
    if (ctl() !== 8'b0001_1000) begin
      n_err++;
      $display("FAIL branch_over_lu: got %b expected %b", ctl(), 8'b0001_1000);
    end
    clear_inputs();
  endtask

  task automatic test_mdu();
    logic [7:0] exp [5];
    exp[0] = 8'b1110_0100;
    exp[1] = 8'b1110_0110;
    exp[2] = 8'b1110_0110;
    exp[3] = 8'b0000_0011;
    exp[4] = 8'b0000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      // PCSrc_E is held high to show it is masked by the MDU sequence.
      mdu_start_E = (i < 4);
      PCSrc_E     = (i < 4);
      #1;
      n_vec++;
      if (ctl() !== exp[i]) begin
        n_err++;
        $display("FAIL mdu_cycle%0d: got %b expected %b", i + 1, ctl(), exp[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_mdu_latency1();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mdu1_start = 1'b1;
      #1;
      n_vec++;
      if ({s1F, s1D, s1E, f1D, f1E, b1M, busy1, done1} !== 8'b0000_0001) begin
        n_err++;
        $display("FAIL mdu_lat1[%0d]: got %b expected %b", i,
                 {s1F, s1D, s1E, f1D, f1E, b1M, busy1, done1}, 8'b0000_0001);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_mdu();
    @(negedge clk);
    mdu_start_E = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (ctl() !== 8'b1110_0110) begin
      n_err++;
      $display("FAIL rst_mdu_pre: got %b expected %b", ctl(), 8'b1110_0110);
    end
    rst_n = 1'b0;
    mdu_start_E = 1'b0;
    #1;
    n_vec++;
    if (ctl() !== 8'b0000_0000) begin
      n_err++;
      $display("FAIL rst_mdu_async: got %b expected %b", ctl(), 8'b0);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    if ({stall_cycles, flush_count} !== 64'd0) begin
      n_err++;
      $display("FAIL rst_perf: got stall=%0d flush=%0d expected 0 0", stall_cycles, flush_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (ctl() !== 8'b0000_0000) begin
      n_err++;
      $display("FAIL rst_mdu_after: got %b expected %b", ctl(), 8'b0);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    @(negedge clk);
    memRead_E = 1'b1; rd_E = 5'd4; rs1_D = 5'd4;
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
    PCSrc_E = 1'b1;
    @(negedge clk);
    clear_inputs();
    #1;
    n_vec++;
    if (stall_cycles !== 32'd2 || flush_count !== 32'd1) begin
      n_err++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d expected 2 1", stall_cycles, flush_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_mdu();
    test_mdu_latency1();
    test_reset_in_mdu();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32I core.
- Drives EX-stage operand forwarding selects, load-use stalls and branch/jump flushes.
- Sequences a fixed-latency multi-cycle unit (MDU) occupying EX, holding upstream stages and bubbling MEM until the unit completes.
- Sits beside the F/D/E/M/W pipeline registers and drives their stall/flush enables.

Parameters:
- MDU_LATENCY, 4, total EX-occupancy cycles of an MDU op (legal 1..16); 1 means no stall.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- rs1_D  in  5  rs1 of instruction in D.
- rs2_D  in  5  rs2 of instruction in D.
- rs1_E  in  5  rs1 of instruction in E.
- rs2_E  in  5  rs2 of instruction in E.
- rd_E  in  5  rd of instruction in E.
- rd_M  in  5  rd of instruction in M.
- rd_W  in  5  rd of instruction in W.
- regWrite_M  in  1  M instruction writes the register file.
- regWrite_W  in  1  W instruction writes the register file.
- memRead_E  in  1  E instruction is a load.
- PCSrc_E  in  1  taken branch or jump resolved in E.
- mdu_start_E  in  1  E instruction is an MDU op; held high while it sits in E.
- forwardA_E  out  2  operand A select: 00 = RD1_E, 10 = ALU result of M, 01 = result of W.
- forwardB_E  out  2  operand B select; same encoding.
- stall_F  out  1  hold PC.
- stall_D  out  1  hold the D register.
- stall_E  out  1  hold the E register.
- flush_D  out  1  clear the D register to a NOP.
- flush_E  out  1  clear the E register to a NOP.
- bubble_M  out  1  load a NOP into the M register.
- mdu_busy  out  1  FSM in MDU_WAIT.
- mdu_done  out  1  one-cycle pulse: MDU result is valid this cycle and E advances.

Behaviour:
- Forwarding (combinational):
  - forwardA_E = 10 if regWrite_M && rd_M != 0 && rd_M == rs1_E.
  - Otherwise 01 if regWrite_W && rd_W != 0 && rd_W == rs1_E.
  - Otherwise 00.
  - M has priority over W. forwardB_E is identical using rs2_E.
- Load-use (combinational): lu = memRead_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D).
- Branch: PCSrc_E asserts flush_D and flush_E.
- FSM states: RUN and MDU_WAIT. 4-bit down-counter cnt.
- RUN:
  - If mdu_start_E && MDU_LATENCY > 1: assert stall_F, stall_D, stall_E, bubble_M; next state MDU_WAIT; cnt <= MDU_LATENCY - 2.
  - If mdu_start_E && MDU_LATENCY == 1: mdu_done = 1, no stall, stay in RUN.
  - Else, if PCSrc_E: flush_D = flush_E = 1; all stalls 0, because the flush overrides load-use.
  - Else, if lu: stall_F = stall_D = 1 and flush_E = 1.
- MDU_WAIT:
  - mdu_start_E is ignored; the op is still in E.
  - mdu_busy = 1.
  - If cnt != 0: assert stall_F, stall_D, stall_E, bubble_M; cnt <= cnt - 1.
  - If cnt == 0: all stalls 0, bubble_M = 0, mdu_done = 1; next state RUN.
  - PCSrc_E and lu are masked in MDU_WAIT. An MDU op never branches, and memRead_E = 0 while the MDU op sits in E.
- Timing: the MDU op occupies E for exactly MDU_LATENCY cycles. The same instruction never retriggers, because it leaves E on the mdu_done cycle.
- Priority: MDU stall > PCSrc_E flush > load-use.
- Reset (asynchronous, rst_n = 0):
  - state = RUN, cnt = 0, mdu_busy = 0.
  - Performance counters = 0.
  - Combinational outputs follow the RUN equations.
  - Reset during MDU_WAIT returns to RUN immediately; stalls drop in the same cycle.
- All flip-flops are clocked on the rising edge of clk.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments every cycle stall_F == 1.
  - flush_count increments every cycle flush_D == 1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: neither the ports nor the counters exist.

Test Plan:
- rd_M = 5, regWrite_M = 1, rd_W = 5, regWrite_W = 1, rs1_E = 5 -> forwardA_E = 10. rd_M = 0, rs1_E = 0 -> forwardA_E = 00.
- memRead_E = 1, rd_E = 7, rs2_D = 7 -> stall_F = stall_D = flush_E = 1 for one cycle. Same with rd_E = 0 -> no stall.
- Load-use condition plus PCSrc_E = 1 in the same cycle -> flush_D = flush_E = 1, stall_F = stall_D = 0.
- MDU_LATENCY = 4, mdu_start_E held -> stall_E high for 3 cycles, bubble_M high 3 cycles, mdu_done on cycle 4, mdu_busy high on cycles 2-4, then RUN.
- MDU_LATENCY = 1, mdu_start_E = 1 -> mdu_done = 1 the same cycle, no stall, mdu_busy stays 0.
- rst_n pulled low on cycle 2 of an MDU_WAIT -> stalls and mdu_busy go 0 asynchronously; after release, mdu_start_E = 0 leaves the FSM in RUN. With HAZARD_PERF_CNT_EN, counters read 0.
